// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU (A)
// and loader/debug (B) ports; one RAM access per grant, req/ack handshake.
module dram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_str,
    input  logic [DATA_W-1:0] ram_dout
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic                owner;       // 0 = A, 1 = B
    logic                last_owner;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    logic                grant_vld;
    logic                grant_b;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // From DONE only the other port may be granted: the owner's req can
    // legally still be high during its ack cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_b   = 1'b0;
        case (state)
            IDLE: begin
                if (a_req && b_req) begin
                    grant_vld = 1'b1;
                    grant_b   = ~last_owner;
                end else if (a_req || b_req) begin
                    grant_vld = 1'b1;
                    grant_b   = b_req;
                end
            end
            DONE: begin
                if (!owner && b_req) begin
                    grant_vld = 1'b1;
                    grant_b   = 1'b1;
                end else if (owner && a_req) begin
                    grant_vld = 1'b1;
                    grant_b   = 1'b0;
                end
            end
            default: ;
        endcase
        sel_we    = grant_b ? b_we    : a_we;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
    end

    // The latched copy drives the RAM directly, so address/data hold their
    // last values outside BUSY and the strobe drops with an async reset.
    assign ram_addr = lat_addr;
    assign ram_din  = lat_wdata;
    assign ram_str  = (state == BUSY) && lat_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (grant_vld) begin
                        owner     <= grant_b;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        state     <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    // Captured for writes too: returns the old word.
                    if (owner) begin
                        b_rdata <= ram_dout;
                        b_ack   <= 1'b1;
                    end else begin
                        a_rdata <= ram_dout;
                        a_ack   <= 1'b1;
                    end
                    last_owner <= owner;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port data RAM (10-bit word address, 32-bit data, combinational read, write on the rising edge of `clk` when `str` is high) between two requesters.
  - Port A: CPU load/store path.
  - Port B: loader/debug path.
- Round-robin arbitration with a req/ack handshake. Exactly one RAM access is performed per grant.
- Sits between the requesters and the RAM address, data and write-strobe inputs. It replaces the direct CPU-to-RAM wiring.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 32, RAM data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held high until a_ack.
- a_we  in  1  port A access type: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  one-cycle pulse: port A access complete.
- a_rdata  out  DATA_W  port A read data; valid while a_ack = 1, then held.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- ram_addr  out  ADDR_W  to RAM address input.
- ram_din  out  DATA_W  to RAM write-data input.
- ram_str  out  1  to RAM write strobe.
- ram_dout  in  DATA_W  from RAM combinational read output.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - ram_addr, ram_din, a_rdata, b_rdata = 0.
  - ram_str, a_ack, b_ack = 0.
  - last_owner = B, so A wins the first tie.
  - ram_str falls immediately on reset assertion. A write in progress is aborted and no ack is issued.
- FSM states: IDLE, BUSY, DONE. Registers:
  - owner (A/B), last_owner.
  - lat_we, lat_addr, lat_wdata.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not last_owner.
  - On grant: at the next edge, latch that port's we/addr/wdata, set owner, go to BUSY.
  - If no req is high, stay in IDLE.
- BUSY (exactly 1 cycle):
  - ram_addr = lat_addr, ram_din = lat_wdata, ram_str = lat_we.
  - At the end-of-cycle edge:
    - The RAM write commits (if lat_we).
    - ram_dout is captured into owner's rdata; this happens for writes too, giving the read-back value of the old word.
    - last_owner = owner; go to DONE.
- DONE (1 cycle):
  - owner's ack = 1; ram_str = 0.
  - The requester drops req during or after this cycle.
  - The arbiter must not grant owner from DONE, since its req may still be high.
  - If the other port's req is high: latch it and go to BUSY. Otherwise go to IDLE.
- Timing:
  - Latency from req sampled high in IDLE to ack = 3 cycles (grant edge, BUSY, DONE).
  - Back-to-back alternating throughput = one access per 2 cycles.
- Outputs are fully registered or decoded from registers only. There is no combinational path from req/addr/wdata to ram_*.
- Request fields may change freely when req = 0. Changes while req = 1 are undefined for the requester, but the latched copy is used once a grant is made.
- ram_addr and ram_din hold their last values in IDLE and DONE. ram_str is 1 only in BUSY with lat_we = 1.
- Starvation: with both ports requesting continuously, grants strictly alternate A, B, A, B...

Test Plan:
- Single write, then single read:
  - A writes addr 0x005 = 0xDEADBEEF: ram_str is high for exactly 1 cycle with ram_addr = 0x005, and a_ack pulses 3 cycles after req.
  - A then reads 0x005: a_rdata = 0xDEADBEEF with a_ack.
- Simultaneous requests from reset:
  - a_req and b_req rise together. A writes 0x001 = 0x11, B writes 0x002 = 0x22.
  - Order is A then B. b_ack arrives 2 cycles after a_ack. RAM[1] = 0x11, RAM[2] = 0x22.
- Continuous contention:
  - Both ports hold req high, re-asserting immediately after ack, for 8 grants.
  - Ack sequence is A, B, A, B, A, B, A, B; never two consecutive acks to the same port.
- Same-port re-request:
  - A asserts req again in the cycle right after a_ack, with B idle.
  - The arbiter passes through IDLE, so the second a_ack comes 3 cycles after the re-request. No double access to the first request.
- Reset mid-access:
  - Drop rst_n during BUSY of an A write to 0x010 = 0x55.
  - ram_str falls asynchronously, no a_ack is issued, RAM[0x010] is unchanged, and all outputs are 0.
- Write read-back:
  - RAM[0x3FF] preloaded with 0xCAFEF00D. B writes 0x3FF = 0x0.
  - b_rdata = 0xCAFEF00D with b_ack. A subsequent B read returns 0x0.
